// File: rtl/sad_block_compare_if.sv
// Handshake and result bus for sad_block_compare: pixel-pair input stream,
// threshold, and block result with optional best-match tracking outputs.
interface sad_block_compare_if #(
    parameter int PIX_W = 8,
    parameter int SAD_W = 12,
    parameter int IDX_W = 8
);
    logic             in_valid;
    logic             in_ready;
    logic [PIX_W-1:0] pix_a;
    logic [PIX_W-1:0] pix_b;
    logic [SAD_W-1:0] thr;
    logic             out_valid;
    logic             out_ready;
    logic [SAD_W-1:0] sad;
    logic             over;
    logic [SAD_W-1:0] best_sad;
    logic [IDX_W-1:0] best_idx;

    modport master (
        output in_valid, pix_a, pix_b, thr, out_ready,
        input  in_ready, out_valid, sad, over, best_sad, best_idx
    );

    modport slave (
        input  in_valid, pix_a, pix_b, thr, out_ready,
        output in_ready, out_valid, sad, over, best_sad, best_idx
    );
endinterface

// File: rtl/sad_block_compare.sv
// Streaming SAD engine: accumulates |a-b| over BLOCK_LEN pairs, then holds the
// saturated SAD and the sad >= thr flag. Macro SAD_BEST_EN adds best-block tracking.
module sad_block_compare #(
    parameter int PIX_W     = 8,
    parameter int BLOCK_LEN = 16,
    parameter int SAD_W     = 12,
    parameter int IDX_W     = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               blk_clr,
    sad_block_compare_if.slave bus
);
    localparam int              CNT_W    = $clog2(BLOCK_LEN);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(BLOCK_LEN - 1);

    typedef enum logic [0:0] {
        ST_ACCUM = 1'b0,
        ST_HOLD  = 1'b1
    } state_t;

    function automatic logic [PIX_W-1:0] abs_diff(input logic [PIX_W-1:0] a,
                                                  input logic [PIX_W-1:0] b);
        if (a >= b) begin
            abs_diff = a - b;
        end else begin
            abs_diff = b - a;
        end
    endfunction

    // The accumulator clamps at all ones instead of wrapping.
    function automatic logic [SAD_W-1:0] sat_add(input logic [SAD_W-1:0] acc,
                                                 input logic [PIX_W-1:0] d);
        logic [SAD_W:0] s;
        s = {1'b0, acc} + (SAD_W+1)'(d);
        if (s[SAD_W]) begin
            sat_add = {SAD_W{1'b1}};
        end else begin
            sat_add = s[SAD_W-1:0];
        end
    endfunction

    state_t             state_r;
    state_t             state_nxt_s;
    logic [CNT_W-1:0]   count_r;
    logic [SAD_W-1:0]   acc_r;
    logic               out_valid_r;
    logic [SAD_W-1:0]   sad_r;
    logic               over_r;
    logic               accept_s;
    logic               last_s;
    logic               consume_s;
    logic [PIX_W-1:0]   diff_s;
    logic [SAD_W-1:0]   sum_s;

    // Datapath arithmetic for the pair currently presented.
    always_comb begin
        diff_s = abs_diff(bus.pix_a, bus.pix_b);
        sum_s  = sat_add(acc_r, diff_s);
    end

    // Next-state and handshake decode; blk_clr blocks both accept and consume.
    always_comb begin
        state_nxt_s = state_r;
        accept_s    = 1'b0;
        last_s      = 1'b0;
        consume_s   = 1'b0;
        case (state_r)
            ST_ACCUM: begin
                if (bus.in_valid && !blk_clr) begin
                    accept_s = 1'b1;
                    if (count_r == LAST_CNT) begin
                        last_s      = 1'b1;
                        state_nxt_s = ST_HOLD;
                    end else begin
                        last_s = 1'b0;
                    end
                end else begin
                    accept_s = 1'b0;
                end
            end
            ST_HOLD: begin
                if (out_valid_r && bus.out_ready && !blk_clr) begin
                    consume_s   = 1'b1;
                    state_nxt_s = ST_ACCUM;
                end else begin
                    consume_s = 1'b0;
                end
            end
            default: begin
                state_nxt_s = ST_ACCUM;
            end
        endcase
        if (blk_clr) begin
            state_nxt_s = ST_ACCUM;
        end else begin
            state_nxt_s = state_nxt_s;
        end
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= ST_ACCUM;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Accumulator, pair counter and registered block result.
    always_ff @(posedge clk) begin
        if (rst) begin
            count_r     <= {CNT_W{1'b0}};
            acc_r       <= {SAD_W{1'b0}};
            out_valid_r <= 1'b0;
            sad_r       <= {SAD_W{1'b0}};
            over_r      <= 1'b0;
        end else if (blk_clr) begin
            count_r     <= {CNT_W{1'b0}};
            acc_r       <= {SAD_W{1'b0}};
            out_valid_r <= 1'b0;
        end else if (last_s) begin
            sad_r       <= sum_s;
            over_r      <= (sum_s >= bus.thr);
            out_valid_r <= 1'b1;
            acc_r       <= {SAD_W{1'b0}};
            count_r     <= {CNT_W{1'b0}};
        end else if (accept_s) begin
            acc_r   <= sum_s;
            count_r <= count_r + CNT_W'(1);
        end else if (consume_s) begin
            out_valid_r <= 1'b0;
        end
    end

    assign bus.in_ready  = (state_r == ST_ACCUM);
    assign bus.out_valid = out_valid_r;
    assign bus.sad       = sad_r;
    assign bus.over      = over_r;

`ifdef SAD_BEST_EN
    logic [SAD_W-1:0] best_sad_r;
    logic [IDX_W-1:0] best_idx_r;
    logic [IDX_W-1:0] blk_idx_r;

    // Minimum SAD since clear; strict compare keeps the earliest block on ties.
    always_ff @(posedge clk) begin
        if (rst || blk_clr) begin
            best_sad_r <= {SAD_W{1'b1}};
            best_idx_r <= {IDX_W{1'b0}};
            blk_idx_r  <= {IDX_W{1'b0}};
        end else if (last_s) begin
            blk_idx_r <= blk_idx_r + IDX_W'(1);
            if (sum_s < best_sad_r) begin
                best_sad_r <= sum_s;
                best_idx_r <= blk_idx_r;
            end
        end
    end

    assign bus.best_sad = best_sad_r;
    assign bus.best_idx = best_idx_r;
`else
    assign bus.best_sad = {SAD_W{1'b0}};
    assign bus.best_idx = {IDX_W{1'b0}};
`endif

endmodule

// File: tb/tb_sad_block_compare.sv
// Self-checking bench for sad_block_compare: a 12-bit and a 9-bit (saturating)
// instance run the same stream against a whole-block arithmetic model.
module tb_sad_block_compare;
    localparam int PIX_W = 8;
    localparam int BLEN  = 4;
    localparam int IW    = 8;

    logic clk = 1'b0;
    logic rst;
    logic blk_clr;
    always #5 clk = ~clk;

    sad_block_compare_if #(.PIX_W(PIX_W), .SAD_W(12), .IDX_W(IW)) bus ();
    sad_block_compare_if #(.PIX_W(PIX_W), .SAD_W(9),  .IDX_W(IW)) bus9 ();

    assign bus9.in_valid  = bus.in_valid;
    assign bus9.pix_a     = bus.pix_a;
    assign bus9.pix_b     = bus.pix_b;
    assign bus9.thr       = bus.thr[8:0];
    assign bus9.out_ready = bus.out_ready;

    sad_block_compare #(.PIX_W(PIX_W), .BLOCK_LEN(BLEN), .SAD_W(12), .IDX_W(IW)) dut (
        .clk(clk), .rst(rst), .blk_clr(blk_clr), .bus(bus)
    );
    sad_block_compare #(.PIX_W(PIX_W), .BLOCK_LEN(BLEN), .SAD_W(9), .IDX_W(IW)) dut9 (
        .clk(clk), .rst(rst), .blk_clr(blk_clr), .bus(bus9)
    );

    typedef struct {
        logic [3:0][7:0] a;
        logic [3:0][7:0] b;
        logic [11:0]     thr;
        logic [11:0]     exp_sad;
        logic            exp_over;
    } vec_t;

    int n_vec = 0;
    int n_err = 0;

    // reference model state
    int best12, bidx12, best9, bidx9, blk;
    int last_sad12, last_over12, last_sad9, last_over9;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [3:0][7:0] pk4(input int v0, input int v1, input int v2, input int v3);
        logic [3:0][7:0] r;
        r[0] = 8'(v0); r[1] = 8'(v1); r[2] = 8'(v2); r[3] = 8'(v3);
        return r;
    endfunction

    function automatic void model_clear();
        best12 = 4095; best9 = 511; bidx12 = 0; bidx9 = 0; blk = 0;
    endfunction

    function automatic void model_block(input int sum, input int thr_v);
        int s12, s9;
        s12 = (sum > 4095) ? 4095 : sum;
        s9  = (sum > 511) ? 511 : sum;
        last_sad12  = s12;
        last_over12 = (s12 >= thr_v) ? 1 : 0;
        last_sad9   = s9;
        last_over9  = (s9 >= (thr_v % 512)) ? 1 : 0;
        if (s12 < best12) begin best12 = s12; bidx12 = blk; end
        if (s9 < best9) begin best9 = s9; bidx9 = blk; end
        blk = (blk + 1) % 256;
    endfunction

    task automatic check_best();
`ifdef SAD_BEST_EN
        chk("best_sad", bus.best_sad, best12);
        chk("best_idx", bus.best_idx, bidx12);
        chk("best_sad9", bus9.best_sad, best9);
        chk("best_idx9", bus9.best_idx, bidx9);
`else
        chk("best_sad_tied", bus.best_sad, 0);
        chk("best_idx_tied", bus.best_idx, 0);
`endif
    endtask

    task automatic check_result();
        chk("out_valid", bus.out_valid, 1);
        chk("in_ready_hold", bus.in_ready, 0);
        chk("sad", bus.sad, last_sad12);
        chk("over", bus.over, last_over12);
        chk("sad9_sat", bus9.sad, last_sad9);
        chk("over9", bus9.over, last_over9);
        chk("out_valid9", bus9.out_valid, 1);
        check_best();
    endtask

    // Feeds one block (thr only meaningful on the last pair) and checks the result.
    task automatic send_block(input logic [3:0][7:0] a, input logic [3:0][7:0] b,
                              input logic [11:0] thr_v, input int max_gap);
        int sum;
        sum = 0;
        for (int i = 0; i < BLEN; i++) begin
            int gap;
            gap = (max_gap > 0) ? int'($urandom_range(0, max_gap)) : 0;
            for (int g = 0; g < gap; g++) begin
                @(negedge clk);
                bus.in_valid = 1'b0;
                bus.pix_a = 8'($urandom);
                bus.pix_b = 8'($urandom);
                bus.thr   = 12'($urandom);
            end
            @(negedge clk);
            if (i == BLEN - 1) chk("no_early_out", bus.out_valid, 0);
            chk("in_ready_accum", bus.in_ready, 1);
            bus.in_valid = 1'b1;
            bus.pix_a = a[i];
            bus.pix_b = b[i];
            bus.thr   = (i == BLEN - 1) ? thr_v : 12'($urandom);
            sum += (int'(a[i]) > int'(b[i])) ? int'(a[i]) - int'(b[i]) : int'(b[i]) - int'(a[i]);
        end
        @(negedge clk);
        bus.in_valid = 1'b0;
        bus.thr = 12'($urandom);
        model_block(sum, int'(thr_v));
        check_result();
    endtask

    // Holds the result for `hold` cycles with a pair offered, then consumes it.
    task automatic consume(input int hold);
        for (int h = 0; h < hold; h++) begin
            bus.out_ready = 1'b0;
            bus.in_valid = 1'b1; bus.pix_a = 8'd200; bus.pix_b = 8'd0;
            @(negedge clk);
            chk("hold_in_ready", bus.in_ready, 0);
            chk("hold_out_valid", bus.out_valid, 1);
            chk("hold_sad", bus.sad, last_sad12);
        end
        bus.out_ready = 1'b1;
        bus.in_valid = 1'b1; bus.pix_a = 8'd200; bus.pix_b = 8'd0;
        @(negedge clk);
        bus.out_ready = 1'b0;
        bus.in_valid = 1'b0;
        chk("consumed_out_valid", bus.out_valid, 0);
        chk("consumed_in_ready", bus.in_ready, 1);
    endtask

    task automatic do_clr();
        @(negedge clk);
        blk_clr = 1'b1;
        bus.in_valid = 1'b1; bus.pix_a = 8'd200; bus.pix_b = 8'd0;
        @(negedge clk);
        blk_clr = 1'b0;
        bus.in_valid = 1'b0;
        model_clear();
        chk("clr_out_valid", bus.out_valid, 0);
        chk("clr_in_ready", bus.in_ready, 1);
        chk("clr_sad_kept", bus.sad, last_sad12);
        chk("clr_over_kept", bus.over, last_over12);
        chk("clr_sad9_kept", bus9.sad, last_sad9);
        check_best();
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        bus.in_valid = 1'b1; bus.pix_a = 8'd200; bus.pix_b = 8'd0;
        @(negedge clk);
        rst = 1'b0;
        bus.in_valid = 1'b0;
        model_clear();
        last_sad12 = 0; last_over12 = 0; last_sad9 = 0; last_over9 = 0;
        chk("rst_out_valid", bus.out_valid, 0);
        chk("rst_in_ready", bus.in_ready, 1);
        chk("rst_sad", bus.sad, 0);
        chk("rst_over", bus.over, 0);
        chk("rst_sad9", bus9.sad, 0);
        check_best();
    endtask

    vec_t tbl[7];

    initial begin
        rst = 1'b1;
        blk_clr = 1'b0;
        bus.in_valid = 1'b0;
        bus.pix_a = 8'd0;
        bus.pix_b = 8'd0;
        bus.thr = 12'd0;
        bus.out_ready = 1'b0;

        tbl[0] = '{pk4(10, 3, 255, 0), pk4(3, 10, 0, 0), 12'd100, 12'd269, 1'b1};
        tbl[1] = '{pk4(7, 7, 7, 7), pk4(7, 7, 7, 7), 12'd0, 12'd0, 1'b1};
        tbl[2] = '{pk4(7, 7, 7, 7), pk4(7, 7, 7, 7), 12'd1, 12'd0, 1'b0};
        tbl[3] = '{pk4(10, 3, 255, 0), pk4(3, 10, 0, 0), 12'd269, 12'd269, 1'b1};
        tbl[4] = '{pk4(10, 3, 255, 0), pk4(3, 10, 0, 0), 12'd270, 12'd269, 1'b0};
        tbl[5] = '{pk4(255, 255, 255, 255), pk4(0, 0, 0, 0), 12'd1020, 12'd1020, 1'b1};
        tbl[6] = '{pk4(0, 0, 0, 0), pk4(255, 255, 255, 255), 12'd4095, 12'd1020, 1'b0};

        repeat (2) @(negedge clk);
        do_reset();

        // directed table, including >= boundaries and 9-bit saturation
        for (int k = 0; k < 7; k++) begin
            send_block(tbl[k].a, tbl[k].b, tbl[k].thr, 0);
            chk("tbl_sad", bus.sad, tbl[k].exp_sad);
            chk("tbl_over", bus.over, tbl[k].exp_over);
            consume(0);
        end

        // result held under back-pressure, next block starts from zero
        send_block(tbl[0].a, tbl[0].b, 12'd100, 0);
        consume(5);
        send_block(pk4(1, 0, 0, 0), pk4(0, 1, 0, 0), 12'd3, 0);
        chk("after_hold_sad", bus.sad, 2);
        consume(0);

        // abort mid-block
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            bus.in_valid = 1'b1; bus.pix_a = 8'd100; bus.pix_b = 8'd0;
        end
        do_clr();
        send_block(pk4(0, 0, 0, 0), pk4(1, 1, 1, 1), 12'd4, 0);
        chk("post_clr_sad", bus.sad, 4);
        consume(0);

        // reset mid-block
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            bus.in_valid = 1'b1; bus.pix_a = 8'd100; bus.pix_b = 8'd0;
        end
        do_reset();
        send_block(pk4(1, 1, 1, 1), pk4(0, 0, 0, 0), 12'd5, 0);
        chk("post_rst_sad", bus.sad, 4);
        consume(0);

        // best tracking: SADs 50, 20, 20, 30
        do_clr();
        send_block(pk4(50, 0, 0, 0), pk4(0, 0, 0, 0), 12'd0, 0); consume(0);
        send_block(pk4(20, 0, 0, 0), pk4(0, 0, 0, 0), 12'd0, 0); consume(0);
        send_block(pk4(0, 20, 0, 0), pk4(0, 0, 0, 0), 12'd0, 0); consume(0);
        send_block(pk4(0, 0, 30, 0), pk4(0, 0, 0, 0), 12'd0, 0);
`ifdef SAD_BEST_EN
        chk("best_seq_sad", bus.best_sad, 20);
        chk("best_seq_idx", bus.best_idx, 1);
`else
        chk("best_seq_sad", bus.best_sad, 0);
        chk("best_seq_idx", bus.best_idx, 0);
`endif
        consume(1);
        do_clr();

        // randomized blocks with idle gaps and back-pressure
        for (int r = 0; r < 40; r++) begin
            logic [3:0][7:0] ra, rb;
            logic [11:0]     rt;
            int              s;
            s = 0;
            for (int i = 0; i < BLEN; i++) begin
                ra[i] = 8'($urandom);
                rb[i] = 8'($urandom);
                s += (int'(ra[i]) > int'(rb[i])) ? int'(ra[i]) - int'(rb[i]) : int'(rb[i]) - int'(ra[i]);
            end
            case ($urandom_range(0, 3))
                0: rt = 12'(s);
                1: rt = 12'(s + 1);
                default: rt = 12'($urandom);
            endcase
            send_block(ra, rb, rt, 2);
            consume(int'($urandom_range(0, 3)));
            if (r == 20) do_clr();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
